lcd_sequenciador: RTL and testbench
===================================

# lcd_sequenciador

Drives an HD44780-compatible character LCD in 8-bit write-only mode. After reset it runs the power-up delay and the display init command sequence. It then transmits 11-byte messages: each message is an 88-bit character/command word plus an 11-bit per-byte RS mask, the same format the instruction encoder produces. The block sits between the encoder and the LCD pins and handles byte ordering, E-pulse generation and per-command settle delays.

## Interface

Parameters:
- POWERUP_CYC, 750000: cycles of idle bus after reset before the first init command (15 ms at 50 MHz).
- E_PULSE_CYC, 25: cycles lcd_e is held high per byte (500 ns).
- SHORT_WAIT_CYC, 2500: settle cycles after a normal byte (50 µs).
- LONG_WAIT_CYC, 100000: settle cycles after a clear/home command (2 ms).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to send the current message; sampled only when busy=0.
- palavra  in  88  message bytes; byte i = palavra[8i+7:8i], i=0..10.
- RS_list  in  11  RS for byte i = RS_list[i]; 1 = data, 0 = command.
- busy  out  1  high during power-up, init and message transfer.
- done  out  1  one-cycle pulse when a message transfer completes.
- lcd_data  out  8  LCD DB7..DB0.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  tied 0 (write only).
- lcd_e  out  1  LCD enable strobe.

## Operation

- States: POWERUP, INIT, IDLE, SETUP, PULSE, WAIT.
- Reset values: busy=1, done=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0, state=POWERUP, byte index=0, cycle counter=0.
- POWERUP: lcd_e=0 for POWERUP_CYC cycles, then go to INIT.
- INIT: sends four commands with RS=0, in order: 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry mode increment). Each command uses SETUP/PULSE/WAIT. After the fourth, go to IDLE. done is not pulsed.
- IDLE: busy=0, lcd_e=0. start=1 latches palavra and RS_list into internal registers, clears the byte index and goes to SETUP. Input changes after latching have no effect on the message.
- Per byte, in every phase:
  - SETUP, 1 cycle: lcd_data and lcd_rs are driven, lcd_e=0.
  - PULSE, E_PULSE_CYC cycles: lcd_e=1.
  - WAIT: lcd_e=0 for the settle count.
  - lcd_data and lcd_rs stay stable from SETUP through the end of WAIT.
- Settle count: LONG_WAIT_CYC when rs=0 and data is 0x01, 0x02 or 0x03; otherwise SHORT_WAIT_CYC. Commands with rs=0 and any other value (e.g. 0x89, set address) use the short wait.
- Message transfer: bytes are sent strictly in order 0..10, all 11 every time. No byte is skipped, including padding home commands.
- After byte 10's WAIT: go to IDLE, done=1 for that one cycle, busy=0.
- start while busy=1 is ignored and is not queued.
- The cycle counter must cover POWERUP_CYC; width is clog2 of the maximum parameter.

## Timing

- Byte time: 1 + E_PULSE_CYC + wait cycles.
- start accepted at edge N gives SETUP for byte 0 in cycle N+1. done is high in cycle N+1+Σ(byte times) of the 11 bytes.
- busy is registered. It rises the cycle after the accepting edge and falls in the done cycle.
- start is accepted in the done cycle: the next message begins with no gap.
- rst asserted at any time, including mid-pulse: lcd_e drops immediately (asynchronously) and all outputs take their reset values. The full POWERUP and INIT sequence reruns after release.
- No glitches on lcd_e: it is a registered output.

## Test plan

All scenarios use POWERUP_CYC=10, E_PULSE_CYC=2, SHORT_WAIT_CYC=4, LONG_WAIT_CYC=8. This gives a short byte of 7 cycles and a long byte of 11 cycles.

- Reset, then release -> lcd_e low for 10 cycles; four E pulses of 2 cycles with data 0x38, 0x0C, 0x01, 0x06 and rs=0; busy falls 42 cycles after release; done never pulses.
- ADD message (bytes 41 44 44 89 5B 31 30 31 30 5D 02, RS_list=0x3F7), start pulsed -> 11 pulses in that order with rs 1,1,1,0,1,1,1,1,1,1,0; last byte uses the long wait; done 82 cycles after the accepting edge.
- CLEAR message (bytes 43 4C 45 41 52 02 02 02 02 02 02, RS_list=0x01F) -> five short bytes, then six long 0x02 commands with rs=0; done 102 cycles after the accepting edge.
- start held high and palavra changed during a transfer -> output bytes match the latched message; only one transfer occurs until done; with start still high, a second transfer begins in the done cycle.
- rst asserted during byte 4's PULSE -> lcd_e=0 and busy=1 in the same cycle; after release the init sequence repeats exactly as in the first scenario; no done pulse.
- start asserted during POWERUP or INIT -> ignored; no message bytes appear before busy first falls.

Source files
------------

// File: rtl/lcd_sequenciador_if.sv
// Encoder-to-LCD bundle: message request side plus the LCD pin group.
// The encoder holds the master modport, the sequencer holds the slave modport.
interface lcd_sequenciador_if;
    logic        start;
    logic [87:0] palavra;
    logic [10:0] RS_list;
    logic        busy;
    logic        done;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;

    modport master (
        output start, palavra, RS_list,
        input  busy, done, lcd_data, lcd_rs, lcd_rw, lcd_e
    );

    modport slave (
        input  start, palavra, RS_list,
        output busy, done, lcd_data, lcd_rs, lcd_rw, lcd_e
    );
endinterface

// File: rtl/lcd_sequenciador.sv
// HD44780 8-bit write-only sequencer: power-up delay, 4-command init, then
// 11-byte messages with per-byte E strobe and command-dependent settle time.
module lcd_sequenciador #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned E_PULSE_CYC    = 25,
    parameter int unsigned SHORT_WAIT_CYC = 2500,
    parameter int unsigned LONG_WAIT_CYC  = 100000
) (
    input  logic               clk,
    input  logic               rst,
    lcd_sequenciador_if.slave  bus
);

    // One counter serves every timed phase, so it is sized by the longest one.
    localparam int unsigned MAX_A   = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
    localparam int unsigned MAX_B   = (SHORT_WAIT_CYC > LONG_WAIT_CYC) ? SHORT_WAIT_CYC : LONG_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    // Top-level phase; INIT and XFER both step bytes through SETUP/PULSE/WAIT,
    // which lets the first init SETUP follow POWERUP with no dispatch cycle.
    typedef enum logic [1:0] {POWERUP, INIT, IDLE, XFER} phase_t;
    typedef enum logic [1:0] {SETUP, PULSE, WAIT} step_t;

    phase_t            phase_q;
    step_t             step_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        idx_q;
    logic [87:0]       msg_q;
    logic [10:0]       rs_list_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        lcd_data_q;
    logic              lcd_rs_q;
    logic              lcd_e_q;

    logic [3:0]        idx_d;
    logic [7:0]        msg_byte_d;
    logic              msg_rs_d;
    logic              long_wait;
    logic [CNT_W-1:0]  wait_last;
    logic              last_byte;

    // Display init commands: 8-bit/2-line/5x8, display on, clear, entry increment.
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign idx_d      = idx_q + 4'd1;
    assign msg_byte_d = msg_q[{idx_d, 3'b000} +: 8];
    assign msg_rs_d   = rs_list_q[idx_d];

    // Clear (0x01) and home (0x02/0x03) need the long settle; every other byte,
    // including other commands such as set-address, uses the short one.
    assign long_wait = !lcd_rs_q && (lcd_data_q inside {8'h01, 8'h02, 8'h03});
    assign wait_last = long_wait ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(SHORT_WAIT_CYC - 1);
    assign last_byte = (phase_q == INIT) ? (idx_q == 4'd3) : (idx_q == 4'd10);

    // Whole sequencer: phase/step control with all pin outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= POWERUP;
            step_q     <= SETUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            // NOTE: the latched message is reset as well so lcd_data can never carry X.
            msg_q      <= '0;
            rs_list_q  <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            lcd_data_q <= 8'h00;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every branch
            // reads the pre-edge values; done defaults low to make it a single pulse.
            done_q <= 1'b0;
            case (phase_q)
                POWERUP: begin
                    if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        phase_q    <= INIT;
                        step_q     <= SETUP;
                        lcd_data_q <= init_cmd(2'd0);
                        lcd_rs_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                IDLE: begin
                    if (bus.start) begin
                        msg_q      <= bus.palavra;
                        rs_list_q  <= bus.RS_list;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        phase_q    <= XFER;
                        step_q     <= SETUP;
                        lcd_data_q <= bus.palavra[7:0];
                        lcd_rs_q   <= bus.RS_list[0];
                    end
                end

                default: begin
                    case (step_q)
                        SETUP: begin
                            lcd_e_q <= 1'b1;
                            cnt_q   <= '0;
                            step_q  <= PULSE;
                        end
                        PULSE: begin
                            if (cnt_q == CNT_W'(E_PULSE_CYC - 1)) begin
                                lcd_e_q <= 1'b0;
                                cnt_q   <= '0;
                                step_q  <= WAIT;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        WAIT: begin
                            if (cnt_q == wait_last) begin
                                cnt_q <= '0;
                                if (last_byte) begin
                                    phase_q <= IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= (phase_q == XFER);
                                end else begin
                                    idx_q  <= idx_d;
                                    step_q <= SETUP;
                                    if (phase_q == INIT) begin
                                        lcd_data_q <= init_cmd(idx_d[1:0]);
                                        lcd_rs_q   <= 1'b0;
                                    end else begin
                                        lcd_data_q <= msg_byte_d;
                                        lcd_rs_q   <= msg_rs_d;
                                    end
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: step_q <= SETUP;
                    endcase
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.lcd_data = lcd_data_q;
    assign bus.lcd_rs   = lcd_rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_e    = lcd_e_q;

endmodule

// File: tb/tb_lcd_sequenciador.sv
// Bench for lcd_sequenciador: expected pin traces are built per byte from the
// timing rules (1 setup + E pulse + settle), then compared cycle by cycle.
module tb_lcd_sequenciador;

    localparam int PU    = 10;
    localparam int EP    = 2;
    localparam int SHORT = 4;
    localparam int LONG  = 8;

    logic clk;
    logic rst;

    lcd_sequenciador_if bus ();

    lcd_sequenciador #(
        .POWERUP_CYC    (PU),
        .E_PULSE_CYC    (EP),
        .SHORT_WAIT_CYC (SHORT),
        .LONG_WAIT_CYC  (LONG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected per-cycle pin state {lcd_e, lcd_rs, lcd_data}.
    logic [9:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int settle(input logic [7:0] d, input logic rs);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? LONG : SHORT;
    endfunction

    // Appends one byte's trace; returns its length in cycles.
    function automatic int model_byte(input logic [7:0] d, input logic rs);
        int w;
        w = settle(d, rs);
        exp_q.push_back({1'b0, rs, d});
        for (int i = 0; i < EP; i++) exp_q.push_back({1'b1, rs, d});
        for (int i = 0; i < w; i++)  exp_q.push_back({1'b0, rs, d});
        return 1 + EP + w;
    endfunction

    function automatic int model_msg(input logic [87:0] w, input logic [10:0] r);
        int sum;
        sum = 0;
        for (int i = 0; i < 11; i++) sum += model_byte(w[8*i +: 8], r[i]);
        return sum;
    endfunction

    function automatic int model_init();
        int sum;
        for (int i = 0; i < PU; i++) exp_q.push_back(10'h000);
        sum = PU;
        sum += model_byte(8'h38, 1'b0);
        sum += model_byte(8'h0C, 1'b0);
        sum += model_byte(8'h01, 1'b0);
        sum += model_byte(8'h06, 1'b0);
        return sum;
    endfunction

    // Samples n negedges starting now; index k of the trace is sample k.
    task automatic observe(input string tag, input int n, input int exp_done, input int exp_idle);
        int         mism;
        int         first_bad;
        int         done_k;
        int         done_cnt;
        int         idle_k;
        logic [9:0] obs;
        mism = 0; first_bad = -1; done_k = -1; done_cnt = 0; idle_k = -1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            obs = {bus.lcd_e, bus.lcd_rs, bus.lcd_data};
            if (k < exp_q.size() && obs !== exp_q[k]) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
            if (bus.lcd_rw !== 1'b0) mism++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (bus.busy === 1'b0 && idle_k < 0) idle_k = k;
        end
        if (mism != 0) $display("%s: first trace difference at cycle %0d", tag, first_bad);
        check({tag, "_trace_errors"}, mism, 0);
        check({tag, "_done_cycle"}, done_k, exp_done);
        check({tag, "_done_count"}, done_cnt, (exp_done < 0) ? 0 : 1);
        check({tag, "_busy_fall"}, idle_k, exp_idle);
    endtask

    function automatic logic [87:0] pack(input logic [7:0] b [11]);
        logic [87:0] w;
        for (int i = 0; i < 11; i++) w[8*i +: 8] = b[i];
        return w;
    endfunction

    task automatic rand_msg(output logic [87:0] w, output logic [10:0] r);
        for (int i = 0; i < 11; i++) begin
            if ($urandom_range(0, 3) == 0) w[8*i +: 8] = 8'($urandom_range(1, 3));
            else                           w[8*i +: 8] = 8'($urandom_range(0, 255));
        end
        r = 11'($urandom);
    endtask

    // Accepts a message after `gap` idle cycles, scrambles the inputs, checks it.
    task automatic send_msg(input string tag, input logic [87:0] w, input logic [10:0] r, input int gap);
        int sum;
        repeat (gap) @(negedge clk);
        bus.palavra = w;
        bus.RS_list = r;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.palavra = {24'($urandom), $urandom, $urandom};
        bus.RS_list = 11'($urandom);
        exp_q.delete();
        sum = model_msg(w, r);
        observe(tag, sum + 1, sum, sum);
    endtask

    logic [7:0]  add_b [11] = '{8'h41, 8'h44, 8'h44, 8'h89, 8'h5B, 8'h31, 8'h30, 8'h31, 8'h30, 8'h5D, 8'h02};
    logic [7:0]  clr_b [11] = '{8'h43, 8'h4C, 8'h45, 8'h41, 8'h52, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};

    initial begin
        logic [87:0] w1, w2, add_w;
        logic [10:0] r1, r2;
        int          s, s1, s2;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.palavra = '0;
        bus.RS_list = '0;
        add_w       = pack(add_b);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1);
        check("rst_done", bus.done, 0);
        check("rst_pins", {bus.lcd_e, bus.lcd_rw, bus.lcd_rs, bus.lcd_data}, 0);

        // Power-up and init after release.
        rst = 1'b0;
        exp_q.delete();
        s = model_init();
        observe("init", s + 1, -1, s);

        // ADD message after a short idle gap.
        send_msg("add", add_w, 11'h3F7, 2);

        // CLEAR message accepted in the done cycle of ADD.
        send_msg("clear", pack(clr_b), 11'h01F, 0);

        // start held high, inputs changed right after latching.
        rand_msg(w1, r1);
        rand_msg(w2, r2);
        @(negedge clk);
        bus.palavra = w1;
        bus.RS_list = r1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.palavra = w2;
        bus.RS_list = r2;
        exp_q.delete();
        s1 = model_msg(w1, r1);
        observe("hold_first", s1 + 1, s1, s1);
        @(negedge clk);
        bus.start = 1'b0;
        exp_q.delete();
        s2 = model_msg(w2, r2);
        observe("hold_second", s2 + 1, s2, s2);

        // Randomized messages with random idle gaps (including zero).
        for (int m = 0; m < 4; m++) begin
            rand_msg(w1, r1);
            send_msg($sformatf("rand%0d", m), w1, r1, $urandom_range(0, 3));
        end

        // Reset during byte 4's E pulse.
        @(negedge clk);
        bus.palavra = add_w;
        bus.RS_list = 11'h3F7;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4 * (1 + EP + SHORT) + 1) @(negedge clk);
        check("midrst_pre_e", {bus.lcd_e, bus.lcd_rs, bus.lcd_data}, {2'b11, 8'h5B});
        #2 rst = 1'b1;
        #1;
        check("midrst_e_low", bus.lcd_e, 0);
        check("midrst_busy", bus.busy, 1);
        check("midrst_data", {bus.lcd_rs, bus.lcd_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        s = model_init();
        observe("reinit", s + 1, -1, s);

        // start held through power-up and init is ignored.
        @(negedge clk);
        rst = 1'b1;
        bus.palavra = add_w;
        bus.RS_list = 11'h3F7;
        bus.start   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        s = model_init();
        observe("start_in_init", s + 1, -1, s);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_init", {bus.busy, bus.lcd_e}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
